// File: rtl/snake_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_display_pkg
// Description : Shared constants for the score display: active-low seven
//               segment encodings {dp,g,f,e,d,c,b,a}, digit count and the
//               active-low anode enable table indexed by strobe slot.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_display_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, decimal point always off (bit 7 high)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Anode enables per slot, active-low, exactly one digit driven per slot
  localparam logic [3:0] ANODE_TABLE [0:NUM_DIGITS-1] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

endpackage : snake_display_pkg
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decoder
// Description : Combinational BCD digit to active-low seven-segment pattern.
//               Blank has priority over dash, dash over the digit value.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
  import snake_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [7:0] o_seg
);

  // Blank beats dash beats digit; out-of-range digits show nothing
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else if (i_dash) begin
      o_seg = SEG_DASH;
    end else begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule : seven_seg_decoder
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Shows the 4-bit game score in decimal on a 4-digit
//               common-anode multiplexed seven-segment display. A prescaler
//               produces one tick per REFRESH_DIV clocks; each tick advances
//               the 2-bit strobe slot. The score is latched at frame start
//               (slot 0) so a frame never mixes two scores.
//               Optional macro SCORE_DISPLAY_BLINK_EN: blink the display
//               while the latched score equals MAX_SCORE.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display
  import snake_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int MAX_SCORE   = 10,
  parameter int BLINK_TICKS = 250
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] SCORE,
  output logic [1:0] STROBE_COUNTER,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] HEX_OUT
);

  localparam int              PRE_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(REFRESH_DIV - 1);
  localparam logic [3:0]      c_max_score = 4'(MAX_SCORE);

  // Refuse to elaborate with a prescaler or blink period that cannot work
  if (REFRESH_DIV < 2 || BLINK_TICKS < 1) begin : g_param_check
    $error("score_display: REFRESH_DIV must be >= 2 and BLINK_TICKS >= 1");
  end

  logic [PRE_W-1:0] r_prescaler;
  logic [1:0]       r_strobe;
  logic [3:0]       r_latched;
  logic [3:0]       r_seg_select;
  logic [7:0]       r_hex;

  logic             w_tick;
  logic [1:0]       w_slot_next;
  logic [3:0]       w_latch_next;
  logic             w_over;
  logic             w_ge10;
  logic [3:0]       w_ones;
  logic [3:0]       w_dec_digit;
  logic             w_dec_blank;
  logic             w_dec_dash;
  logic [7:0]       w_dec_seg;
  logic             w_blink_phase_next;

  assign w_tick      = (r_prescaler == c_pre_last);
  assign w_slot_next = r_strobe + 2'd1;

  // A new score is only taken on the tick that starts a frame; the display
  // registers load on that same edge, so they decode from the next value.
  assign w_latch_next = (w_tick && (w_slot_next == 2'd0)) ? SCORE : r_latched;

  // Binary to two-digit decimal; scores above the legal range show dashes
  assign w_over = (w_latch_next > c_max_score);
  assign w_ge10 = (w_latch_next >= 4'd10);
  assign w_ones = w_ge10 ? (w_latch_next - 4'd10) : w_latch_next;

  // Prescaler, strobe slot and frame-boundary score latch
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_prescaler <= '0;
      r_strobe    <= 2'd0;
      r_latched   <= 4'd0;
    end else begin
      r_prescaler <= w_tick ? '0 : (r_prescaler + PRE_W'(1));
      if (w_tick) begin
        r_strobe <= w_slot_next;
      end
      r_latched <= w_latch_next;
    end
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  localparam int              BC_W      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BC_W-1:0] c_bc_last = BC_W'(BLINK_TICKS - 1);

  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink_phase;
  logic [BC_W-1:0] w_blink_cnt_next;

  // Blink runs only while the score sits at the maximum, otherwise it is parked
  always_comb begin
    w_blink_cnt_next   = r_blink_cnt;
    w_blink_phase_next = r_blink_phase;
    if (w_latch_next != c_max_score) begin
      w_blink_cnt_next   = '0;
      w_blink_phase_next = 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == c_bc_last) begin
        w_blink_cnt_next   = '0;
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_blink_cnt_next   = r_blink_cnt + BC_W'(1);
      end
    end
  end

  // Blink tick counter and phase
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt   <= w_blink_cnt_next;
      r_blink_phase <= w_blink_phase_next;
    end
  end
`else
  assign w_blink_phase_next = 1'b0;
`endif

  // Choose what the slot being entered should show
  always_comb begin
    w_dec_digit = 4'd0;
    w_dec_blank = 1'b1;
    w_dec_dash  = 1'b0;
    case (w_slot_next)
      2'd0: begin
        w_dec_digit = w_ones;
        w_dec_blank = 1'b0;
        w_dec_dash  = w_over;
      end
      2'd1: begin
        w_dec_digit = 4'd1;
        w_dec_blank = ~w_ge10 & ~w_over;
        w_dec_dash  = w_over;
      end
      default: ;
    endcase
    if (w_blink_phase_next) begin
      w_dec_blank = 1'b1;
    end
  end

  seven_seg_decoder u_decoder (
    .i_digit (w_dec_digit),
    .i_blank (w_dec_blank),
    .i_dash  (w_dec_dash),
    .o_seg   (w_dec_seg)
  );

  // Anode and segment registers load together on each tick
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_seg_select <= 4'b1111;
      r_hex        <= SEG_BLANK;
    end else if (w_tick) begin
      r_seg_select <= ANODE_TABLE[w_slot_next];
      r_hex        <= w_dec_seg;
    end
  end

  assign STROBE_COUNTER = r_strobe;
  assign SEG_SELECT     = r_seg_select;
  assign HEX_OUT        = r_hex;

endmodule : score_display
`default_nettype wire
